// File: rtl/id_stage_gen.sv
// rtl/id_stage_gen.sv - parametrised ID stage: GRF, immediates, redirect, forwarding, ID/EX register
module id_stage_gen #(
  parameter int XLEN      = 32,
  parameter int NFWD      = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [31:0]          id_instr_i,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_pending_i,
  input  logic [5*NFWD-1:0]    fwd_addr_i,
  input  logic [XLEN*NFWD-1:0] fwd_data_i,
  input  logic                 ex_ready_i,
  output logic                 ex_valid_o,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [31:0]          ex_instr_o,
  output logic [XLEN-1:0]      ex_a_o,
  output logic [XLEN-1:0]      ex_b_o,
  output logic [XLEN-1:0]      ex_imm_o,
  output logic [1:0]           pc_sel_o,
  output logic [XLEN-1:0]      pc_target_o
);

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  logic [XLEN-1:0] grf_q [32];

  logic [4:0]      op_addr [2];
  logic [XLEN-1:0] op_val  [2];
  logic            op_hit  [2];
  logic            op_hz   [2];

  logic            hazard;
  logic            fire;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;
  logic [XLEN-1:0] imm_lui;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] br_target;
  logic            a_neg;
  logic            a_zero;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [31:0]     ex_instr_q, ex_instr_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d;
  logic [XLEN-1:0] ex_b_q, ex_b_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;

  assign op_addr[0] = id_instr_i[25:21];
  assign op_addr[1] = id_instr_i[20:16];

  // GRF write port; entry 0 is never written so it stays zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (wb_we_i && (wb_addr_i != 5'd0)) begin
      grf_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Operand read: GRF (with optional WB bypass), overridden by the highest-priority matching source
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      op_hit[o] = 1'b0;
      op_hz[o]  = 1'b0;
      if (op_addr[o] == 5'd0)
        op_val[o] = '0;
      else if ((WB_BYPASS != 0) && wb_we_i && (wb_addr_i == op_addr[o]))
        op_val[o] = wb_data_i;
      else
        op_val[o] = grf_q[op_addr[o]];
      for (int k = 0; k < NFWD; k++) begin
        if (!op_hit[o] && (op_addr[o] != 5'd0) && fwd_valid_i[k] &&
            (fwd_addr_i[5*k +: 5] == op_addr[o])) begin
          op_hit[o] = 1'b1;
          op_hz[o]  = fwd_pending_i[k];
          op_val[o] = fwd_data_i[XLEN*k +: XLEN];
        end
      end
    end
  end

  assign hazard     = op_hz[0] | op_hz[1];
  assign id_ready_o = flush_i | (!hazard & (!ex_valid_q | ex_ready_i));
  assign fire       = id_valid_i & id_ready_o & !flush_i;

  assign opcode    = id_instr_i[31:26];
  assign funct     = id_instr_i[5:0];
  assign imm16     = id_instr_i[15:0];
  assign imm_sext  = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm_zext  = {{(XLEN-16){1'b0}}, imm16};
  assign imm_lui   = imm_sext << 16;
  assign br_target = id_pc_i + XLEN'(4) + (imm_sext << 2);
  assign a_neg     = op_val[0][XLEN-1];
  assign a_zero    = (op_val[0] == '0);

  // Immediate extension selected by opcode
  always_comb begin
    imm_ext = imm_sext;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = imm_zext;
      OP_LUI:                   imm_ext = imm_lui;
      default:                  imm_ext = imm_sext;
    endcase
  end

  // Redirect decision; only an accepted instruction may steer the fetch
  always_comb begin
    pc_sel_o    = 2'd0;
    pc_target_o = '0;
    if (fire) begin
      case (opcode)
        OP_BEQ:  if (op_val[0] == op_val[1]) begin pc_sel_o = 2'd1; pc_target_o = br_target; end
        OP_BNE:  if (op_val[0] != op_val[1]) begin pc_sel_o = 2'd1; pc_target_o = br_target; end
        OP_BLEZ: if (a_neg || a_zero)        begin pc_sel_o = 2'd1; pc_target_o = br_target; end
        OP_BGTZ: if (!a_neg && !a_zero)      begin pc_sel_o = 2'd1; pc_target_o = br_target; end
        OP_REGIMM: begin
          if ((op_addr[1] == 5'd0 && a_neg) || (op_addr[1] == 5'd1 && !a_neg)) begin
            pc_sel_o    = 2'd1;
            pc_target_o = br_target;
          end
        end
        OP_J, OP_JAL: begin
          pc_sel_o    = 2'd2;
          pc_target_o = {id_pc_i[XLEN-1:28], id_instr_i[25:0], 2'b00};
        end
        OP_RTYPE: begin
          if (funct == FN_JR || funct == FN_JALR) begin
            pc_sel_o    = 2'd3;
            pc_target_o = op_val[0];
          end
        end
        default: ;
      endcase
    end
  end

  // ID/EX next state: flush, then fire, then drain on ex_ready, else hold
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_instr_d = ex_instr_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (fire) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = id_pc_i;
      ex_instr_d = id_instr_i;
      ex_a_d     = op_val[0];
      ex_b_d     = op_val[1];
      ex_imm_d   = imm_ext;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_instr_q <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_instr_q <= ex_instr_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_pc_o    = ex_pc_q;
  assign ex_instr_o = ex_instr_q;
  assign ex_a_o     = ex_a_q;
  assign ex_b_o     = ex_b_q;
  assign ex_imm_o   = ex_imm_q;

endmodule

// File: doc/id_stage_gen.md
Name: id_stage_gen

Overview:
- Parametrised successor to the fixed 32-bit decode stage.
- Contains the register file, immediate extension, branch/jump resolution and N-source operand forwarding.
- Adds internal forwarding-address matching, load-use stall detection, a valid/ready handshake and flush support.
- Sits between the IF/ID and EX stages; owns the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width (32 or 64)
NFWD, 2, number of forwarding sources (1..4), index 0 = highest priority
WB_BYPASS, 1, 1 = a GRF write in the same cycle as a read returns the written data

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  kill the instruction in ID; load a bubble into ID/EX
id_valid  in  1  IF/ID holds a valid instruction
id_ready  out  1  ID accepts the instruction this cycle
id_instr  in  32  instruction in ID
id_pc  in  XLEN  PC of the instruction in ID
wb_we  in  1  GRF write enable
wb_addr  in  5  GRF write address
wb_data  in  XLEN  GRF write data
fwd_valid  in  NFWD  source k carries a register-writing instruction
fwd_pending  in  NFWD  source k result is not yet available (for example, a load in EX)
fwd_addr  in  5*NFWD  destination register of source k
fwd_data  in  XLEN*NFWD  result of source k
ex_ready  in  1  EX accepts the ID/EX contents
ex_valid  out  1  ID/EX holds a valid instruction
ex_pc, ex_instr  out  XLEN, 32  registered PC and instruction
ex_a, ex_b, ex_imm  out  XLEN each  registered forwarded rs, forwarded rt and extended immediate
pc_sel  out  2  0 = sequential, 1 = branch taken, 2 = j/jal, 3 = jr/jalr
pc_target  out  XLEN  redirect target

Behaviour:
- Reset (reset=0, asynchronous):
  - All 32 GRF entries, ex_valid, ex_pc, ex_instr, ex_a, ex_b and ex_imm go to 0.
  - Combinational outputs follow their definitions.
- GRF:
  - Two read ports (rs = instr[25:21], rt = instr[20:16]) and one write port on the clk edge.
  - Register $0 always reads 0; writes to it are ignored.
  - WB_BYPASS=1 with wb_we=1 and wb_addr equal to a nonzero read address: the read returns wb_data in the same cycle.
- Forwarding for each operand:
  - Select the lowest index k with fwd_valid[k]=1, fwd_addr[k] equal to the operand address, and the operand address nonzero.
  - If none matches, use the GRF value.
  - If the selected source has fwd_pending[k]=1, a hazard exists. Pending sources still block lower-priority matches.
  - rs and rt are always treated as used (conservative).
- id_ready = flush | (!hazard & (!ex_valid | ex_ready)).
- fire = id_valid & id_ready & !flush.
- Immediate extension:
  - andi, ori, xori (0x0C–0x0E): zero-extend.
  - lui (0x0F): imm << 16, sign-extended to XLEN.
  - All other opcodes: sign-extend.
  - Branch offset = sext(imm) << 2.
- Redirect (driven only when fire=1, otherwise pc_sel=0 and pc_target=0):
  - beq 0x04 (a==b), bne 0x05 (a!=b), blez 0x06 (a signed <= 0), bgtz 0x07 (a signed > 0), REGIMM 0x01 with rt=0 bltz (a < 0) or rt=1 bgez (a >= 0).
  - A taken branch gives pc_sel=1 and target = id_pc + 4 + offset, wrapping modulo 2^XLEN. A not-taken branch gives pc_sel=0.
  - j 0x02 / jal 0x03 give pc_sel=2 and target = {pc[XLEN-1:28], instr[25:0], 2'b00}.
  - R-type funct 0x08 jr / 0x09 jalr give pc_sel=3 and target = forwarded a.
  - Comparisons use the forwarded operands.
- ID/EX register, one rule per clk edge, in priority order:
  - flush: ex_valid <= 0 (payload don't-care, held).
  - else fire: load id_pc, id_instr, the forwarded a and b, and imm; ex_valid <= 1.
  - else if ex_ready: ex_valid <= 0 (bubble for hazard or !id_valid).
  - else hold.
- Latency: one cycle from fire to ex_valid.
- Simultaneous flush and hazard: flush wins; id_ready=1 and the instruction is dropped.
- Simultaneous GRF write and forwarding match: the forwarding source wins over WB.
- Reset mid-stall clears ex_valid immediately; the GRF is cleared.

Test Plan:
- Reset sequencing: reset=0, then 1. Expect ex_valid=0 and rd($5)=0. Write $5=0x1234 via WB, then issue addu reading $5. Expect ex_a=0x1234 one cycle after fire.
- Forward priority: fwd_valid=2'b11, both addr=8, data0=0xAAAA, data1=0xBBBB, GRF $8=0xCCCC. Expect ex_a=0xAAAA. Drop valid[0]: expect 0xBBBB. Set addr=0: expect 0.
- Load-use stall: fwd_pending[0]=1, fwd_addr[0]=9, instruction rs=9. Expect id_ready=0 and a bubble into EX (ex_valid=0 after the edge). Clear pending with data 0x77: expect fire and ex_a=0x77.
- Branches: beq with a=b=3, pc=0x400, imm=0xFFFF. Expect pc_sel=1, target=0x400. bgtz with a=0xFFFFFFFF: expect pc_sel=0. jr with a forwarded as 0x3000: expect pc_sel=3, target=0x3000.
- Backpressure and flush: ex_valid=1, ex_ready=0. Expect id_ready=0 and ID/EX held for 3 cycles. Assert flush: expect id_ready=1, pc_sel=0, ex_valid=0 next cycle.
- Immediates: ori imm=0x8000 gives ex_imm=0x00008000. addiu imm=0x8000 gives 0xFFFF8000. lui 0x1234 gives 0x12340000. Repeat with XLEN=64: sign-extension fills the upper 32 bits.
